// File: rtl/g_reg_flags.sv
// g_reg_flags: G result register with Z/N/C/V flag capture, condition-code
// evaluation, and a DEPTH-entry LIFO used to save/restore {G, flags} across
// interrupt and call sequences.
module g_reg_flags #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] G_in,
  input  logic             G_write,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic [2:0]       cond_sel,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] G_out,
  output logic [3:0]       flags_out,
  output logic             G_cond_check,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int CW = $clog2(DEPTH + 1);
  // Storage is addressed with exactly AW bits; for non-power-of-two DEPTH the
  // spare slots are simply never written.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = WIDTH + 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Flag bit positions within the {Z, N, C, V} nibble.
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  logic [WIDTH-1:0] g_q, g_d;
  logic [3:0]       flags_q, flags_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [EW-1:0]    stack_mem [2**AW];

  logic             full, empty;
  logic             push_ok, pop_ok, err_ev;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [EW-1:0]    top_entry;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);

  // A push and pop together cancel each other and count as an error.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err_ev  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  assign wr_idx    = count_q[AW-1:0];
  // count > 0 whenever this is used, and count-1 < DEPTH <= 2**AW, so the
  // modulo-2**AW subtraction yields the correct top slot.
  assign rd_idx    = wr_idx - AW'(1);
  assign top_entry = stack_mem[rd_idx];

  // Next-state for G, flags, stack count and sticky error.
  always_comb begin
    g_d     = g_q;
    flags_d = flags_q;
    count_d = count_q;
    err_d   = err_q;

    // G_write has priority over a restoring pop; the popped entry is dropped.
    if (G_write) begin
      g_d         = G_in;
      flags_d[FZ] = (G_in == '0);
      flags_d[FN] = G_in[WIDTH-1];
      flags_d[FC] = carry_in;
      flags_d[FV] = ovf_in;
    end else if (pop_ok) begin
      g_d     = top_entry[EW-1:4];
      flags_d = top_entry[3:0];
    end

    if (push_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      count_d = count_q - CW'(1);
    end

    // A new error on the clearing edge keeps the flag set.
    if (err_ev) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Control/state registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      g_q     <= '0;
      flags_q <= 4'b1000;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      g_q     <= g_d;
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack storage: saves the pre-edge {G, flags}; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok && resetn) begin
      stack_mem[wr_idx] <= {g_q, flags_q};
    end
  end

  // Condition-code decode from the registered flags.
  always_comb begin
    G_cond_check = 1'b0;
    case (cond_sel)
      3'b000:  G_cond_check = flags_q[FZ];
      3'b001:  G_cond_check = ~flags_q[FZ];
      3'b010:  G_cond_check = flags_q[FN] ^ flags_q[FV];
      3'b011:  G_cond_check = ~(flags_q[FN] ^ flags_q[FV]);
      3'b100:  G_cond_check = flags_q[FC];
      3'b101:  G_cond_check = ~flags_q[FC];
      3'b110:  G_cond_check = 1'b1;
      default: G_cond_check = 1'b0;
    endcase
  end

  assign G_out       = g_q;
  assign flags_out   = flags_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_g_reg_flags.sv
// Directed bench for g_reg_flags (WIDTH=16, DEPTH=4).
module tb_g_reg_flags;

  logic        clock;
  logic        resetn;
  logic [15:0] G_in;
  logic        G_write;
  logic        carry_in;
  logic        ovf_in;
  logic [2:0]  cond_sel;
  logic        push;
  logic        pop;
  logic        err_clr;
  logic [15:0] G_out;
  logic [3:0]  flags_out;
  logic        G_cond_check;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  int errors = 0;
  int checks = 0;

  g_reg_flags #(.WIDTH(16), .DEPTH(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .G_in         (G_in),
    .G_write      (G_write),
    .carry_in     (carry_in),
    .ovf_in       (ovf_in),
    .cond_sel     (cond_sel),
    .push         (push),
    .pop          (pop),
    .err_clr      (err_clr),
    .G_out        (G_out),
    .flags_out    (flags_out),
    .G_cond_check (G_cond_check),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_err    (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set after this return are sampled on the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] v, input logic c, input logic o);
    G_in = v; carry_in = c; ovf_in = o; G_write = 1'b1;
    step();
    G_write = 1'b0; carry_in = 1'b0; ovf_in = 1'b0;
  endtask

  task automatic do_push();
    push = 1'b1; step(); push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  task automatic do_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  logic [7:0] reset_cond_exp;

  initial begin
    resetn = 1'b0; G_in = '0; G_write = 1'b0; carry_in = 1'b0; ovf_in = 1'b0;
    cond_sel = 3'b000; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    // Reset held across several edges.
    repeat (3) step();
    chk("rst_G", 32'(G_out), 32'h0000);
    chk("rst_flags", 32'(flags_out), 32'h8);
    chk("rst_empty", 32'(stack_empty), 32'h1);
    chk("rst_full", 32'(stack_full), 32'h0);
    chk("rst_err", 32'(stack_err), 32'h0);
    // EQ NE LT GE CS CC AL NV with Z=1,N=0,C=0,V=0 (bit i = cond_sel i).
    reset_cond_exp = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      cond_sel = 3'(i);
      #1;
      chk($sformatf("rst_cond%0d", i), 32'(G_cond_check), 32'(reset_cond_exp[i]));
    end
    resetn = 1'b1;
    step();

    // Flag capture: 0x8000 with carry -> Z0 N1 C1 V0.
    wr(16'h8000, 1'b1, 1'b0);
    chk("cap_G", 32'(G_out), 32'h8000);
    chk("cap_flags", 32'(flags_out), 32'h6);
    cond_sel = 3'b010; #1; chk("cap_LT", 32'(G_cond_check), 32'h1);
    cond_sel = 3'b100; #1; chk("cap_CS", 32'(G_cond_check), 32'h1);
    cond_sel = 3'b000; #1; chk("cap_EQ", 32'(G_cond_check), 32'h0);
    wr(16'h0000, 1'b0, 1'b0);
    chk("zero_flags", 32'(flags_out), 32'h8);
    cond_sel = 3'b001; #1; chk("zero_NE", 32'(G_cond_check), 32'h0);

    // Push/pop round trip.
    wr(16'h1234, 1'b0, 1'b0);
    do_push();
    wr(16'hFFFF, 1'b0, 1'b1);
    chk("ffff_flags", 32'(flags_out), 32'h5);
    do_push();
    do_pop();
    chk("pop1_G", 32'(G_out), 32'hFFFF);
    chk("pop1_V", 32'(flags_out[0]), 32'h1);
    do_pop();
    chk("pop2_G", 32'(G_out), 32'h1234);
    chk("pop2_flags", 32'(flags_out), 32'h0);
    chk("pop2_empty", 32'(stack_empty), 32'h1);
    chk("pop2_err", 32'(stack_err), 32'h0);

    // Fill to DEPTH with distinct values, then overflow.
    for (int i = 0; i < 4; i++) begin
      wr(16'h0100 + 16'(i), 1'b0, 1'b0);
      chk($sformatf("fill_full_before%0d", i), 32'(stack_full), 32'h0);
      do_push();
    end
    chk("fill_full", 32'(stack_full), 32'h1);
    chk("fill_err0", 32'(stack_err), 32'h0);
    wr(16'h0BAD, 1'b0, 1'b0);
    do_push();
    chk("ovf_err", 32'(stack_err), 32'h1);
    chk("ovf_full", 32'(stack_full), 32'h1);
    for (int i = 3; i >= 0; i--) begin
      do_pop();
      chk($sformatf("drain_G%0d", i), 32'(G_out), 32'h0100 + 32'(i));
    end
    chk("drain_empty", 32'(stack_empty), 32'h1);
    do_clr();
    chk("clr_err", 32'(stack_err), 32'h0);

    // Pop while empty.
    do_pop();
    chk("upf_G", 32'(G_out), 32'h0100);
    chk("upf_err", 32'(stack_err), 32'h1);
    chk("upf_empty", 32'(stack_empty), 32'h1);
    // Clear colliding with a fresh error keeps it set.
    err_clr = 1'b1; pop = 1'b1; step(); err_clr = 1'b0; pop = 1'b0;
    chk("clr_collide_err", 32'(stack_err), 32'h1);
    do_clr();
    chk("clr2_err", 32'(stack_err), 32'h0);

    // push + G_write: stack keeps the old value.
    wr(16'h0055, 1'b0, 1'b0);
    push = 1'b1; G_in = 16'h00AA; G_write = 1'b1;
    step();
    push = 1'b0; G_write = 1'b0;
    chk("pw_G", 32'(G_out), 32'h00AA);
    chk("pw_empty", 32'(stack_empty), 32'h0);
    do_pop();
    chk("pw_pop_G", 32'(G_out), 32'h0055);

    // pop + G_write: write wins, count still drops.
    do_push();
    pop = 1'b1; G_in = 16'h0001; G_write = 1'b1;
    step();
    pop = 1'b0; G_write = 1'b0;
    chk("pgw_G", 32'(G_out), 32'h0001);
    chk("pgw_empty", 32'(stack_empty), 32'h1);
    chk("pgw_err", 32'(stack_err), 32'h0);

    // push + pop together: both ignored, error raised.
    do_push();
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    chk("pp_err", 32'(stack_err), 32'h1);
    chk("pp_G", 32'(G_out), 32'h0001);
    chk("pp_empty", 32'(stack_empty), 32'h0);
    do_pop();
    chk("pp_pop_empty", 32'(stack_empty), 32'h1);
    chk("pp_pop_G", 32'(G_out), 32'h0001);
    do_clr();

    // Asynchronous reset mid-stack with count = 3.
    do_push(); do_push(); do_push();
    wr(16'h7777, 1'b1, 1'b1);
    chk("ar_pre_G", 32'(G_out), 32'h7777);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_G", 32'(G_out), 32'h0000);
    chk("ar_flags", 32'(flags_out), 32'h8);
    chk("ar_empty", 32'(stack_empty), 32'h1);
    chk("ar_err", 32'(stack_err), 32'h0);
    #2;
    resetn = 1'b1;
    do_pop();
    chk("ar_pop_err", 32'(stack_err), 32'h1);
    chk("ar_pop_G", 32'(G_out), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
